// File: rtl/pc_pkg.sv
// ============================================================================
// Module      : pc_pkg
// Description : Shared FSM state type and default vectors for the PC unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } pc_state_e;

    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VECTOR   = 32'h8000_0180;

endpackage : pc_pkg

`default_nettype wire

// File: rtl/pc_next_sel.sv
// ============================================================================
// Module      : pc_next_sel
// Description : Combinational next-PC priority select and misalignment check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_sel
    import pc_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] EXC_VECTOR = PC_EXC_VECTOR,
    parameter int                    INC        = 4
) (
    input  logic                  exc_req_i,
    input  logic                  branch_taken_i,
    input  logic [DATA_WIDTH-1:0] branch_target_i,
    input  logic                  jr_i,
    input  logic [DATA_WIDTH-1:0] jr_target_i,
    input  logic                  jump_i,
    input  logic [DATA_WIDTH-1:0] jump_target_i,
    input  logic [DATA_WIDTH-1:0] pc_plus_inc_i,
    output logic [DATA_WIDTH-1:0] next_addr_o,
    output logic                  redir_o,
    output logic [DATA_WIDTH-1:0] redir_addr_o,
    output logic                  misalign_o,
    output logic [DATA_WIDTH-1:0] raw_target_o
);

    logic                  redir_d;
    logic [DATA_WIDTH-1:0] raw_d;
    logic                  misaligned_d;

    always_comb begin
        redir_d = 1'b0;
        raw_d   = '0;
        if (branch_taken_i) begin
            redir_d = 1'b1;
            raw_d   = branch_target_i;
        end else if (jr_i) begin
            redir_d = 1'b1;
            raw_d   = jr_target_i;
        end else if (jump_i) begin
            redir_d = 1'b1;
            raw_d   = jump_target_i;
        end
    end

    // Word alignment only means something for a 4-byte fetch stride.
    generate
        if (INC == 4) begin : g_align_chk
            assign misaligned_d = redir_d && (raw_d[1:0] != 2'b00);
        end else begin : g_no_chk
            assign misaligned_d = 1'b0;
        end
    endgenerate

    assign redir_o      = redir_d;
    assign raw_target_o = raw_d;
    assign misalign_o   = misaligned_d;
    assign redir_addr_o = misaligned_d ? EXC_VECTOR : raw_d;
    assign next_addr_o  = exc_req_i ? EXC_VECTOR :
                          redir_d   ? redir_addr_o : pc_plus_inc_i;

endmodule : pc_next_sel

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
// Module      : pc_unit
// Description : Program counter with stall, deferred redirect and exceptions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit
    import pc_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = PC_RESET_VECTOR,
    parameter logic [DATA_WIDTH-1:0] EXC_VECTOR   = PC_EXC_VECTOR,
    parameter int                    INC          = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  exc_req,
    input  logic                  branch_taken,
    input  logic [DATA_WIDTH-1:0] branch_target,
    input  logic                  jr,
    input  logic [DATA_WIDTH-1:0] jr_target,
    input  logic                  jump,
    input  logic [DATA_WIDTH-1:0] jump_target,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] pc_plus_inc,
    output logic                  redirect_pending,
    output logic                  misalign_exc,
    output logic [DATA_WIDTH-1:0] bad_addr
);

    pc_state_e             state_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pend_q;
    logic                  misalign_q;
    logic [DATA_WIDTH-1:0] bad_addr_q;

    logic [DATA_WIDTH-1:0] pc_plus_inc_d;
    logic [DATA_WIDTH-1:0] next_addr_d;
    logic                  redir_d;
    logic [DATA_WIDTH-1:0] redir_addr_d;
    logic                  misalign_d;
    logic [DATA_WIDTH-1:0] raw_target_d;

    assign pc_plus_inc_d = pc_q + DATA_WIDTH'(INC);

    pc_next_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .EXC_VECTOR (EXC_VECTOR),
        .INC        (INC)
    ) u_next_sel (
        .exc_req_i       (exc_req),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .jr_i            (jr),
        .jr_target_i     (jr_target),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .pc_plus_inc_i   (pc_plus_inc_d),
        .next_addr_o     (next_addr_d),
        .redir_o         (redir_d),
        .redir_addr_o    (redir_addr_d),
        .misalign_o      (misalign_d),
        .raw_target_o    (raw_target_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_VECTOR;
            pend_q     <= '0;
            misalign_q <= 1'b0;
            bad_addr_q <= '0;
        end else begin
            misalign_q <= 1'b0;
            if (exc_req) begin
                pc_q    <= EXC_VECTOR;
                pend_q  <= '0;
                state_q <= ST_RUN;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        // Misalignment is flagged whether the target is loaded or captured.
                        if (redir_d && misalign_d) begin
                            misalign_q <= 1'b1;
                            bad_addr_q <= raw_target_d;
                        end
                        if (!stall) begin
                            pc_q <= next_addr_d;
                        end else if (redir_d) begin
                            pend_q  <= redir_addr_d;
                            state_q <= ST_PEND;
                        end
                    end
                    ST_PEND: begin
                        // New redirects are ignored here; the captured one wins.
                        if (!stall) begin
                            pc_q    <= pend_q;
                            state_q <= ST_RUN;
                        end
                    end
                    default: begin
                        state_q <= ST_RUN;
                    end
                endcase
            end
        end
    end

    assign pc_out           = pc_q;
    assign pc_plus_inc      = pc_plus_inc_d;
    assign redirect_pending = (state_q == ST_PEND);
    assign misalign_exc     = misalign_q;
    assign bad_addr         = bad_addr_q;

endmodule : pc_unit

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
// Module      : tb_pc_unit
// Description : Table-driven directed bench for pc_unit, plus an INC=2 instance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_unit;

    localparam logic [31:0] EXC = 32'h8000_0180;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        exc;
        logic        br;
        logic [31:0] brt;
        logic        jr;
        logic [31:0] jrt;
        logic        jp;
        logic [31:0] jpt;
        logic [31:0] e_pc;
        logic        e_pend;
        logic        e_mis;
        logic [31:0] e_bad;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, stall, exc_req, branch_taken, jr, jump;
    logic [31:0] branch_target, jr_target, jump_target;
    logic [31:0] pc_out, pc_plus_inc, bad_addr;
    logic        redirect_pending, misalign_exc;

    logic        rst2, jump2;
    logic [31:0] jump_target2;
    logic [31:0] pc_out2, pc_plus_inc2, bad_addr2;
    logic        pend2, mis2;

    int n_total = 0;
    int n_pass  = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    pc_unit dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .exc_req          (exc_req),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .jr               (jr),
        .jr_target        (jr_target),
        .jump             (jump),
        .jump_target      (jump_target),
        .pc_out           (pc_out),
        .pc_plus_inc      (pc_plus_inc),
        .redirect_pending (redirect_pending),
        .misalign_exc     (misalign_exc),
        .bad_addr         (bad_addr)
    );

    pc_unit #(.INC(2)) dut2 (
        .clk              (clk),
        .rst              (rst2),
        .stall            (1'b0),
        .exc_req          (1'b0),
        .branch_taken     (1'b0),
        .branch_target    (32'h0),
        .jr               (1'b0),
        .jr_target        (32'h0),
        .jump             (jump2),
        .jump_target      (jump_target2),
        .pc_out           (pc_out2),
        .pc_plus_inc      (pc_plus_inc2),
        .redirect_pending (pend2),
        .misalign_exc     (mis2),
        .bad_addr         (bad_addr2)
    );

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [vec %0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
    endtask

    task automatic add(input logic r, input logic s, input logic e,
                       input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt,
                       input logic p, input logic [31:0] pt,
                       input logic [31:0] epc, input logic epend,
                       input logic emis, input logic [31:0] ebad);
        vec_t v;
        v.rst = r; v.stall = s; v.exc = e;
        v.br = b; v.brt = bt; v.jr = j; v.jrt = jt; v.jp = p; v.jpt = pt;
        v.e_pc = epc; v.e_pend = epend; v.e_mis = emis; v.e_bad = ebad;
        vq.push_back(v);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; exc_req = 1'b0;
        branch_taken = 1'b0; jr = 1'b0; jump = 1'b0;
        branch_target = '0; jr_target = '0; jump_target = '0;
        rst2 = 1'b1; jump2 = 1'b0; jump_target2 = '0;

        //  rst s  e  br  brt          jr  jrt          jp  jpt           pc            pend mis bad
        add(1, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,        32'h0,        0, 0, 32'h0);
        add(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,        32'h4,        0, 0, 32'h0);
        add(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,        32'h8,        0, 0, 32'h0);
        add(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,        32'hC,        0, 0, 32'h0);
        add(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,        32'h10,       0, 0, 32'h0);
        add(0, 1, 0, 1, 32'h40,      0, 32'h0,       0, 32'h0,        32'h10,       1, 0, 32'h0);
        add(0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,        32'h10,       1, 0, 32'h0);
        add(0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,        32'h10,       1, 0, 32'h0);
        add(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,        32'h40,       0, 0, 32'h0);
        add(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,        32'h44,       0, 0, 32'h0);
        add(0, 0, 0, 1, 32'h100,     1, 32'h200,     1, 32'h300,      32'h100,      0, 0, 32'h0);
        add(0, 0, 0, 0, 32'h0,       1, 32'h200,     1, 32'h300,      32'h200,      0, 0, 32'h0);
        add(0, 0, 0, 0, 32'h0,       0, 32'h0,       1, 32'h300,      32'h300,      0, 0, 32'h0);
        add(0, 0, 0, 0, 32'h0,       1, 32'h42,      0, 32'h0,        EXC,          0, 1, 32'h42);
        add(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,        EXC + 4,      0, 0, 32'h42);
        add(0, 1, 0, 1, 32'h40,      0, 32'h0,       0, 32'h0,        EXC + 4,      1, 0, 32'h42);
        add(0, 1, 0, 0, 32'h0,       0, 32'h0,       1, 32'h500,      EXC + 4,      1, 0, 32'h42);
        add(0, 0, 0, 1, 32'h600,     0, 32'h0,       0, 32'h0,        32'h40,       0, 0, 32'h42);
        add(0, 1, 0, 1, 32'h80,      0, 32'h0,       0, 32'h0,        32'h40,       1, 0, 32'h42);
        add(0, 1, 1, 0, 32'h0,       0, 32'h0,       0, 32'h0,        EXC,          0, 0, 32'h42);
        add(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,        EXC + 4,      0, 0, 32'h42);
        add(0, 1, 0, 1, 32'h123,     0, 32'h0,       0, 32'h0,        EXC + 4,      1, 1, 32'h123);
        add(0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,        EXC + 4,      1, 0, 32'h123);
        add(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,        EXC,          0, 0, 32'h123);
        add(0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,        EXC,          0, 0, 32'h123);
        add(0, 0, 1, 1, 32'h700,     0, 32'h0,       0, 32'h0,        EXC,          0, 0, 32'h123);
        add(0, 1, 0, 1, 32'h40,      0, 32'h0,       0, 32'h0,        EXC,          1, 0, 32'h123);
        add(1, 1, 0, 1, 32'h80,      0, 32'h0,       0, 32'h0,        32'h0,        0, 0, 32'h0);
        add(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,        32'h4,        0, 0, 32'h0);
        add(0, 0, 0, 0, 32'h0,       0, 32'h0,       1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, 32'h0);
        add(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,        32'h0,        0, 0, 32'h0);
        add(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,        32'h4,        0, 0, 32'h0);
        add(1, 0, 1, 0, 32'h0,       1, 32'h88,      0, 32'h0,        32'h0,        0, 0, 32'h0);

        for (int i = 0; i < vq.size(); i++) begin
            rst           = vq[i].rst;
            stall         = vq[i].stall;
            exc_req       = vq[i].exc;
            branch_taken  = vq[i].br;
            branch_target = vq[i].brt;
            jr            = vq[i].jr;
            jr_target     = vq[i].jrt;
            jump          = vq[i].jp;
            jump_target   = vq[i].jpt;
            @(posedge clk);
            #1;
            chk("pc_out",           i, pc_out,                   vq[i].e_pc);
            chk("pc_plus_inc",      i, pc_plus_inc,              vq[i].e_pc + 32'd4);
            chk("redirect_pending", i, {31'b0, redirect_pending}, {31'b0, vq[i].e_pend});
            chk("misalign_exc",     i, {31'b0, misalign_exc},    {31'b0, vq[i].e_mis});
            chk("bad_addr",         i, bad_addr,                 vq[i].e_bad);
        end

        // INC=2 instance: odd-halfword targets are legal, no check applied.
        rst2 = 1'b0;
        jump2 = 1'b1; jump_target2 = 32'h42;
        @(posedge clk); #1;
        chk("inc2_pc",       100, pc_out2, 32'h42);
        chk("inc2_misalign", 100, {31'b0, mis2}, 32'h0);
        chk("inc2_bad_addr", 100, bad_addr2, 32'h0);
        jump2 = 1'b0;
        @(posedge clk); #1;
        chk("inc2_seq_pc",   101, pc_out2, 32'h44);
        chk("inc2_plus_inc", 101, pc_plus_inc2, 32'h46);
        chk("inc2_misalign", 101, {31'b0, mis2}, 32'h0);
        chk("inc2_pending",  101, {31'b0, pend2}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pc_unit

`default_nettype wire
